mode_controller: RTL and testbench
==================================

MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 SHALL have parameter NUM_SLOT, default 4, number of record slots (range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 23, SDRAM word-address width.
REQ-003 SHALL have parameter SLOT_DEPTH, default 2**21, words per slot; slot base address = index*SLOT_DEPTH.
REQ-004 SHALL have ports:
 i_clk  in  1  system clock.
 i_rst  in  1  asynchronous active-high reset.
 i_key  in  4  debounced level keys, active-high: [0] REC, [1] PLAY, [2] STOP, [3] unused.
 i_sw  in  18  switches: [0] MIX request, [1] PITCH request, [2 +: NUM_SLOT] mix mask, [15:13] slot index, [16] pitch mode, [17] unused.
 i_pitch_speed  in  4  pitch speed code.
 i_load_done  in  1  initial data load complete.
 o_mode  out  4  current state code.
 o_slot_err  out  1  one-cycle pulse when the selected slot index >= NUM_SLOT.
 o_rec_start / o_rec_pause / o_rec_stop  out  1 each; o_rec_addr  out  ADDR_W; i_rec_done  in  1.
 o_play_start / o_play_pause / o_play_stop  out  1 each; o_play_addr  out  ADDR_W; i_play_done  in  1.
 o_mix_start  out  1; o_mix_mask  out  NUM_SLOT; o_mix_num  out  4; i_mix_done  in  1.
 o_pitch_start  out  1; o_pitch_mode  out  1; o_pitch_speed  out  4; o_pitch_addr  out  ADDR_W; i_pitch_done  in  1.

Function
REQ-005 SHALL register i_key and act only on rising edges (key event = key & ~key_q).
REQ-006 SHALL implement states INIT=0, IDLE=1, REC=2, PLAY=3, MIX=4, PITCH=5; o_mode = state code.
REQ-007 INIT SHALL go to IDLE on the first cycle with i_load_done=1; all key events and switches SHALL be ignored in INIT.
REQ-008 IDLE priority SHALL be REC event > PLAY event > i_sw[0] > i_sw[1]; only one transition per cycle.
REQ-009 Entering REC/PLAY/PITCH SHALL latch the slot index; if index >= NUM_SLOT, SHALL stay in IDLE and pulse o_slot_err.
REQ-010 o_*_addr SHALL hold the latched slot base address for the whole operation, truncated to ADDR_W.
REQ-011 Each *_start SHALL be a single-cycle pulse on the first cycle in the corresponding active state, not a level.
REQ-012 In REC, a REC event SHALL toggle o_rec_pause; in PLAY, a PLAY event SHALL toggle o_play_pause; the pause flag SHALL clear on return to IDLE.
REQ-013 A STOP event in REC/PLAY SHALL produce a one-cycle *_stop pulse; the state SHALL remain until the matching done.
REQ-014 On the matching *_done=1, the state SHALL return to IDLE in the next cycle; done inputs of other engines SHALL be ignored.
REQ-015 Done and STOP in the same cycle: done SHALL win and no stop pulse SHALL be issued.
REQ-016 MIX entry SHALL latch o_mix_mask = i_sw[2 +: NUM_SLOT] and o_mix_num = popcount(mask); a zero mask SHALL keep the state in IDLE.
REQ-017 PITCH entry SHALL latch o_pitch_mode = i_sw[16] and o_pitch_speed = i_pitch_speed; o_pitch_speed=0 SHALL be treated as 1.
REQ-018 Latched outputs SHALL not change while in an active state, regardless of switch activity.

Reset
REQ-019 i_rst SHALL asynchronously force state INIT; all pulse, pause, mask, num, mode, speed and address outputs SHALL be 0; key history SHALL be cleared.
REQ-020 Reset mid-operation SHALL abort without issuing a stop pulse; after release, behaviour SHALL follow REQ-007.

Configuration
REQ-021 With MODE_CTRL_PITCH_EN defined, PITCH state and pitch outputs SHALL behave per REQ-017; undefined, i_sw[1] SHALL be ignored, PITCH SHALL be unreachable, and pitch outputs SHALL be tied to 0.

Structure
REQ-022 State enum, key-index constants and switch-field offsets SHALL reside in package mode_ctrl_pkg.
REQ-023 Key edge detection SHALL be a sub-module key_edge, parametrised by width.

Verification
REQ-024 Reset, i_load_done=0 for 10 cycles with REC pressed -> o_mode stays 0; i_load_done=1 -> o_mode=1 next cycle.
REQ-025 Slot index 2, REC press -> o_rec_start one cycle, o_rec_addr=0x400000; REC press -> o_rec_pause=1; STOP -> o_rec_stop one cycle; i_rec_done -> o_mode=1.
REQ-026 NUM_SLOT=4, slot index 5, PLAY press -> o_slot_err one cycle, o_mode stays 1, o_play_start never asserted.
REQ-027 i_sw[0]=1, mask 4'b1011 -> o_mix_start pulse, o_mix_num=3; mask changed to 4'b0001 mid-mix -> outputs unchanged; mask 0 -> no transition.
REQ-028 In PLAY, STOP event and i_play_done in the same cycle -> no o_play_stop, o_mode=1 next cycle.
REQ-029 Reset asserted in PLAY with pause=1 -> all outputs 0 immediately, no stop pulse; MODE_CTRL_PITCH_EN undefined with i_sw[1]=1 -> o_mode stays 1.

Source files
------------

// File: rtl/mode_ctrl_pkg.sv
// rtl/mode_ctrl_pkg.sv - shared state codes, key/switch field positions and helpers for mode_controller
package mode_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT  = 4'd0,
        ST_IDLE  = 4'd1,
        ST_REC   = 4'd2,
        ST_PLAY  = 4'd3,
        ST_MIX   = 4'd4,
        ST_PITCH = 4'd5
    } state_t;

    localparam int KEY_W    = 4;
    localparam int KEY_REC  = 0;
    localparam int KEY_PLAY = 1;
    localparam int KEY_STOP = 2;

    localparam int SW_W          = 18;
    localparam int SW_MIX        = 0;
    localparam int SW_PITCH      = 1;
    localparam int SW_MASK_LSB   = 2;
    localparam int SW_SLOT_LSB   = 13;
    localparam int SW_SLOT_W     = 3;
    localparam int SW_PITCH_MODE = 16;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - registers level keys and flags their rising edges
module key_edge #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] key_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_q <= '0;
        end else begin
            key_q <= key;
        end
    end

    assign rise = key & ~key_q;

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - record/play/mix/pitch mode sequencer with slot addressing
// Optional pitch path is built only when MODE_CTRL_PITCH_EN is defined.
module mode_controller
    import mode_ctrl_pkg::*;
#(
    parameter int NUM_SLOT   = 4,
    parameter int ADDR_W     = 23,
    parameter int SLOT_DEPTH = 2**21
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [3:0]          i_key,
    input  logic [17:0]         i_sw,
    input  logic [3:0]          i_pitch_speed,
    input  logic                i_load_done,
    output logic [3:0]          o_mode,
    output logic                o_slot_err,
    output logic                o_rec_start,
    output logic                o_rec_pause,
    output logic                o_rec_stop,
    output logic [ADDR_W-1:0]   o_rec_addr,
    input  logic                i_rec_done,
    output logic                o_play_start,
    output logic                o_play_pause,
    output logic                o_play_stop,
    output logic [ADDR_W-1:0]   o_play_addr,
    input  logic                i_play_done,
    output logic                o_mix_start,
    output logic [NUM_SLOT-1:0] o_mix_mask,
    output logic [3:0]          o_mix_num,
    input  logic                i_mix_done,
    output logic                o_pitch_start,
    output logic                o_pitch_mode,
    output logic [3:0]          o_pitch_speed,
    output logic [ADDR_W-1:0]   o_pitch_addr,
    input  logic                i_pitch_done
);

    state_t                state;
    logic [KEY_W-1:0]      key_ev;
    logic [SW_SLOT_W-1:0]  slot_idx;
    logic                  slot_bad;
    logic [63:0]           base_full;
    logic [ADDR_W-1:0]     slot_base;
    logic [NUM_SLOT-1:0]   mask_in;
    logic [3:0]            mask_cnt;

    key_edge #(
        .WIDTH (KEY_W)
    ) u_key_edge (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .key   (i_key),
        .rise  (key_ev)
    );

    assign slot_idx  = i_sw[SW_SLOT_LSB +: SW_SLOT_W];
    assign slot_bad  = {1'b0, slot_idx} >= 4'(NUM_SLOT);
    assign base_full = 64'(slot_idx) * 64'(SLOT_DEPTH);
    assign slot_base = base_full[ADDR_W-1:0];
    assign mask_in   = i_sw[SW_MASK_LSB +: NUM_SLOT];
    assign mask_cnt  = popcount8(8'(mask_in));
    assign o_mode    = state;

    // Only part of the switch bank, the spare key and the high product bits feed logic.
    logic unused_ok;
    assign unused_ok = ^{i_sw, key_ev[3], base_full, i_pitch_speed, i_pitch_done};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_INIT;
            o_slot_err    <= 1'b0;
            o_rec_start   <= 1'b0;
            o_rec_pause   <= 1'b0;
            o_rec_stop    <= 1'b0;
            o_rec_addr    <= '0;
            o_play_start  <= 1'b0;
            o_play_pause  <= 1'b0;
            o_play_stop   <= 1'b0;
            o_play_addr   <= '0;
            o_mix_start   <= 1'b0;
            o_mix_mask    <= '0;
            o_mix_num     <= 4'd0;
`ifdef MODE_CTRL_PITCH_EN
            o_pitch_start <= 1'b0;
            o_pitch_mode  <= 1'b0;
            o_pitch_speed <= 4'd0;
            o_pitch_addr  <= '0;
`endif
        end else begin
            o_slot_err    <= 1'b0;
            o_rec_start   <= 1'b0;
            o_rec_stop    <= 1'b0;
            o_play_start  <= 1'b0;
            o_play_stop   <= 1'b0;
            o_mix_start   <= 1'b0;
`ifdef MODE_CTRL_PITCH_EN
            o_pitch_start <= 1'b0;
`endif
            case (state)
                ST_INIT: begin
                    if (i_load_done) begin
                        state <= ST_IDLE;
                    end
                end

                // The highest-priority request is consumed even if it is rejected.
                ST_IDLE: begin
                    if (key_ev[KEY_REC]) begin
                        if (slot_bad) begin
                            o_slot_err <= 1'b1;
                        end else begin
                            state       <= ST_REC;
                            o_rec_start <= 1'b1;
                            o_rec_addr  <= slot_base;
                        end
                    end else if (key_ev[KEY_PLAY]) begin
                        if (slot_bad) begin
                            o_slot_err <= 1'b1;
                        end else begin
                            state        <= ST_PLAY;
                            o_play_start <= 1'b1;
                            o_play_addr  <= slot_base;
                        end
                    end else if (i_sw[SW_MIX]) begin
                        if (mask_in != '0) begin
                            state       <= ST_MIX;
                            o_mix_start <= 1'b1;
                            o_mix_mask  <= mask_in;
                            o_mix_num   <= mask_cnt;
                        end
                    end
`ifdef MODE_CTRL_PITCH_EN
                    else if (i_sw[SW_PITCH]) begin
                        if (slot_bad) begin
                            o_slot_err <= 1'b1;
                        end else begin
                            state         <= ST_PITCH;
                            o_pitch_start <= 1'b1;
                            o_pitch_mode  <= i_sw[SW_PITCH_MODE];
                            o_pitch_speed <= (i_pitch_speed == 4'd0) ? 4'd1 : i_pitch_speed;
                            o_pitch_addr  <= slot_base;
                        end
                    end
`endif
                end

                // Done takes precedence over a simultaneous stop request.
                ST_REC: begin
                    if (i_rec_done) begin
                        state       <= ST_IDLE;
                        o_rec_pause <= 1'b0;
                    end else begin
                        if (key_ev[KEY_STOP]) begin
                            o_rec_stop <= 1'b1;
                        end
                        if (key_ev[KEY_REC]) begin
                            o_rec_pause <= ~o_rec_pause;
                        end
                    end
                end

                ST_PLAY: begin
                    if (i_play_done) begin
                        state        <= ST_IDLE;
                        o_play_pause <= 1'b0;
                    end else begin
                        if (key_ev[KEY_STOP]) begin
                            o_play_stop <= 1'b1;
                        end
                        if (key_ev[KEY_PLAY]) begin
                            o_play_pause <= ~o_play_pause;
                        end
                    end
                end

                ST_MIX: begin
                    if (i_mix_done) begin
                        state <= ST_IDLE;
                    end
                end

`ifdef MODE_CTRL_PITCH_EN
                ST_PITCH: begin
                    if (i_pitch_done) begin
                        state <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

`ifndef MODE_CTRL_PITCH_EN
    assign o_pitch_start = 1'b0;
    assign o_pitch_mode  = 1'b0;
    assign o_pitch_speed = 4'd0;
    assign o_pitch_addr  = '0;
`endif

endmodule

// File: tb/tb_mode_controller.sv
// tb/tb_mode_controller.sv - directed self-checking bench for mode_controller (default build)
module tb_mode_controller;

    localparam int NUM_SLOT = 4;
    localparam int ADDR_W   = 23;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [3:0]          i_key;
    logic [17:0]         i_sw;
    logic [3:0]          i_pitch_speed;
    logic                i_load_done;
    logic [3:0]          o_mode;
    logic                o_slot_err;
    logic                o_rec_start, o_rec_pause, o_rec_stop;
    logic [ADDR_W-1:0]   o_rec_addr;
    logic                i_rec_done;
    logic                o_play_start, o_play_pause, o_play_stop;
    logic [ADDR_W-1:0]   o_play_addr;
    logic                i_play_done;
    logic                o_mix_start;
    logic [NUM_SLOT-1:0] o_mix_mask;
    logic [3:0]          o_mix_num;
    logic                i_mix_done;
    logic                o_pitch_start, o_pitch_mode;
    logic [3:0]          o_pitch_speed;
    logic [ADDR_W-1:0]   o_pitch_addr;
    logic                i_pitch_done;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mode_controller #(
        .NUM_SLOT   (NUM_SLOT),
        .ADDR_W     (ADDR_W),
        .SLOT_DEPTH (2**21)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_key         (i_key),
        .i_sw          (i_sw),
        .i_pitch_speed (i_pitch_speed),
        .i_load_done   (i_load_done),
        .o_mode        (o_mode),
        .o_slot_err    (o_slot_err),
        .o_rec_start   (o_rec_start),
        .o_rec_pause   (o_rec_pause),
        .o_rec_stop    (o_rec_stop),
        .o_rec_addr    (o_rec_addr),
        .i_rec_done    (i_rec_done),
        .o_play_start  (o_play_start),
        .o_play_pause  (o_play_pause),
        .o_play_stop   (o_play_stop),
        .o_play_addr   (o_play_addr),
        .i_play_done   (i_play_done),
        .o_mix_start   (o_mix_start),
        .o_mix_mask    (o_mix_mask),
        .o_mix_num     (o_mix_num),
        .i_mix_done    (i_mix_done),
        .o_pitch_start (o_pitch_start),
        .o_pitch_mode  (o_pitch_mode),
        .o_pitch_speed (o_pitch_speed),
        .o_pitch_addr  (o_pitch_addr),
        .i_pitch_done  (i_pitch_done)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_key = 4'd0; i_sw = 18'd0; i_pitch_speed = 4'd0;
        i_load_done = 1'b0; i_rec_done = 1'b0; i_play_done = 1'b0;
        i_mix_done = 1'b0; i_pitch_done = 1'b0;
        tick(); tick();
        chk("rst_mode", 32'(o_mode), 32'd0);
        chk("rst_pulses", 32'({o_slot_err, o_rec_start, o_rec_stop, o_play_start, o_play_stop, o_mix_start}), 32'd0);
        chk("rst_mix_mask", 32'(o_mix_mask), 32'd0);
        i_rst = 1'b0;

        // Held in INIT while load is pending, keys ignored
        i_key = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        chk("init_hold_mode", 32'(o_mode), 32'd0);
        chk("init_no_rec", 32'(o_rec_start), 32'd0);
        i_key = 4'b0000;
        i_load_done = 1'b1;
        tick();
        chk("init_to_idle", 32'(o_mode), 32'd1);

        // Record on slot 2
        i_sw[15:13] = 3'd2;
        i_key = 4'b0001; tick();
        chk("rec_mode", 32'(o_mode), 32'd2);
        chk("rec_start_hi", 32'(o_rec_start), 32'd1);
        chk("rec_addr", 32'(o_rec_addr), 32'h400000);
        i_key = 4'b0000; tick();
        chk("rec_start_lo", 32'(o_rec_start), 32'd0);
        i_key = 4'b0001; tick();
        chk("rec_pause_on", 32'(o_rec_pause), 32'd1);
        i_key = 4'b0000; tick();
        i_key = 4'b0100; tick();
        chk("rec_stop_hi", 32'(o_rec_stop), 32'd1);
        chk("rec_stop_mode", 32'(o_mode), 32'd2);
        i_key = 4'b0000; tick();
        chk("rec_stop_lo", 32'(o_rec_stop), 32'd0);
        i_play_done = 1'b1; tick();
        chk("rec_ignore_play_done", 32'(o_mode), 32'd2);
        i_play_done = 1'b0;
        i_rec_done = 1'b1; tick();
        chk("rec_done_idle", 32'(o_mode), 32'd1);
        chk("rec_pause_clr", 32'(o_rec_pause), 32'd0);
        i_rec_done = 1'b0;

        // Out-of-range slot is rejected
        i_sw[15:13] = 3'd5;
        i_key = 4'b0010; tick();
        chk("slot_err_hi", 32'(o_slot_err), 32'd1);
        chk("slot_err_mode", 32'(o_mode), 32'd1);
        chk("slot_err_no_play", 32'(o_play_start), 32'd0);
        i_key = 4'b0000; tick();
        chk("slot_err_lo", 32'(o_slot_err), 32'd0);
        chk("slot_err_no_play2", 32'(o_play_start), 32'd0);

        // Highest valid slot boundary
        i_sw[15:13] = 3'd3;
        i_key = 4'b0001; tick();
        chk("slot3_addr", 32'(o_rec_addr), 32'h600000);
        i_key = 4'b0000;
        i_rec_done = 1'b1; tick();
        i_rec_done = 1'b0;
        chk("slot3_back_idle", 32'(o_mode), 32'd1);

        // Mix with latched mask
        i_sw[0] = 1'b1; i_sw[5:2] = 4'b1011; tick();
        chk("mix_mode", 32'(o_mode), 32'd4);
        chk("mix_start_hi", 32'(o_mix_start), 32'd1);
        chk("mix_num", 32'(o_mix_num), 32'd3);
        chk("mix_mask", 32'(o_mix_mask), 32'hB);
        i_sw[5:2] = 4'b0001; tick();
        chk("mix_start_lo", 32'(o_mix_start), 32'd0);
        chk("mix_mask_held", 32'(o_mix_mask), 32'hB);
        chk("mix_num_held", 32'(o_mix_num), 32'd3);
        i_sw[0] = 1'b0; i_mix_done = 1'b1; tick();
        chk("mix_done_idle", 32'(o_mode), 32'd1);
        i_mix_done = 1'b0;
        i_sw[0] = 1'b1; i_sw[5:2] = 4'b0000; tick();
        chk("mix_zero_mode", 32'(o_mode), 32'd1);
        chk("mix_zero_start", 32'(o_mix_start), 32'd0);
        i_sw[0] = 1'b0;

        // Play, pause, then STOP coinciding with done
        i_sw[15:13] = 3'd1;
        i_key = 4'b0010; tick();
        chk("play_mode", 32'(o_mode), 32'd3);
        chk("play_start_hi", 32'(o_play_start), 32'd1);
        chk("play_addr", 32'(o_play_addr), 32'h200000);
        i_key = 4'b0000; tick();
        i_key = 4'b0010; tick();
        chk("play_pause_on", 32'(o_play_pause), 32'd1);
        i_key = 4'b0000; tick();
        i_key = 4'b0100; i_play_done = 1'b1; tick();
        chk("play_done_wins_stop", 32'(o_play_stop), 32'd0);
        chk("play_done_idle", 32'(o_mode), 32'd1);
        chk("play_pause_clr", 32'(o_play_pause), 32'd0);
        i_key = 4'b0000; i_play_done = 1'b0; tick();
        chk("play_no_late_stop", 32'(o_play_stop), 32'd0);

        // Reset while paused in PLAY
        i_key = 4'b0010; tick();
        i_key = 4'b0000; tick();
        i_key = 4'b0010; tick();
        chk("play2_pause_on", 32'(o_play_pause), 32'd1);
        i_key = 4'b0000;
        i_rst = 1'b1; #1;
        chk("arst_mode", 32'(o_mode), 32'd0);
        chk("arst_outs", 32'({o_play_pause, o_play_stop, o_play_start, o_rec_pause}), 32'd0);
        chk("arst_addr", 32'(o_play_addr), 32'd0);
        i_load_done = 1'b0;
        tick();
        chk("arst_no_stop", 32'(o_play_stop), 32'd0);
        i_rst = 1'b0; tick();
        chk("post_rst_init", 32'(o_mode), 32'd0);
        i_load_done = 1'b1; tick();
        chk("post_rst_idle", 32'(o_mode), 32'd1);

        // Pitch request is ignored in the default build
        i_sw[1] = 1'b1; i_pitch_speed = 4'd7;
        tick(); tick(); tick();
        chk("pitch_off_mode", 32'(o_mode), 32'd1);
        chk("pitch_off_outs", 32'({o_pitch_start, o_pitch_mode, o_pitch_speed}), 32'd0);
        chk("pitch_off_addr", 32'(o_pitch_addr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
